// File: rtl/cmp_pkg.sv
// Shared types for the iterative comparator: op encoding, FSM states and
// small helpers used by cmp_iter and cmp_chunk.
package cmp_pkg;

  typedef logic [2:0] cmp_op_t;

  localparam cmp_op_t OP_EQ   = 3'b000;
  localparam cmp_op_t OP_NE   = 3'b001;
  localparam cmp_op_t OP_SLT  = 3'b010;
  localparam cmp_op_t OP_SLTU = 3'b011;
  localparam cmp_op_t OP_LT   = 3'b100;
  localparam cmp_op_t OP_GE   = 3'b101;
  localparam cmp_op_t OP_LTU  = 3'b110;
  localparam cmp_op_t OP_GEU  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } cmp_state_t;

  function automatic bit cmp_width_ok(input int xlen, input int chunk);
    return (chunk > 0) && (xlen >= chunk) && ((xlen % chunk) == 0);
  endfunction

  function automatic logic cmp_is_signed(input cmp_op_t op);
    case (op)
      OP_SLT, OP_LT, OP_GE: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic cmp_result_bit(input cmp_op_t op, input logic eq, input logic lt);
    case (op)
      OP_EQ:                           return eq;
      OP_NE:                           return ~eq;
      OP_SLT, OP_SLTU, OP_LT, OP_LTU:  return lt;
      OP_GE, OP_GEU:                   return ~lt;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational CHUNK-bit compare; flip_i inverts the chunk MSB so the
// top chunk of a signed compare can reuse the unsigned comparator.
module cmp_chunk
  import cmp_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             flip_i,
  output logic             eq_o,
  output logic             lt_o
);

  logic [CHUNK-1:0] flip_mask_s;
  logic [CHUNK-1:0] a_x_s;
  logic [CHUNK-1:0] b_x_s;

  assign flip_mask_s = {flip_i, {(CHUNK-1){1'b0}}};
  assign a_x_s       = a_i ^ flip_mask_s;
  assign b_x_s       = b_i ^ flip_mask_s;
  assign eq_o        = (a_x_s == b_x_s);
  assign lt_o        = (a_x_s < b_x_s);

endmodule

// File: rtl/cmp_iter.sv
// Iterative RV32 comparator scanning CHUNK bits per cycle, MSB chunk first.
// Optional: define CMP_ITER_EARLY_EXIT_EN to stop at the first differing chunk.
module cmp_iter
  import cmp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            eq,
  output logic            lt
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  if (!cmp_width_ok(XLEN, CHUNK)) begin : g_bad_width
    $error("cmp_iter: XLEN must be a non-zero multiple of CHUNK");
  end

  cmp_state_t state_q, state_d;
  logic [NCHUNK-1:0][CHUNK-1:0] a_q, a_d, b_q, b_d;
  cmp_op_t         op_q, op_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            diff_q, diff_d;
  logic            lt_acc_q, lt_acc_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            eq_q, eq_d;
  logic            lt_q, lt_d;

  logic chunk_eq_s, chunk_lt_s, flip_s, scan_done_s, fin_eq_s, fin_lt_s;

  assign flip_s = cmp_is_signed(op_q) && (idx_q == IDX_TOP);

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i    (a_q[idx_q]),
    .b_i    (b_q[idx_q]),
    .flip_i (flip_s),
    .eq_o   (chunk_eq_s),
    .lt_o   (chunk_lt_s)
  );

`ifdef CMP_ITER_EARLY_EXIT_EN
  assign scan_done_s = !chunk_eq_s || (idx_q == '0);
`else
  assign scan_done_s = (idx_q == '0);
`endif

  // A latched earlier difference overrides whatever the lower chunks say.
  assign fin_eq_s = !diff_q && chunk_eq_s;
  assign fin_lt_s = diff_q ? lt_acc_q : (!chunk_eq_s && chunk_lt_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)    state_d = ST_SCAN; else state_d = ST_IDLE;
      ST_SCAN: if (scan_done_s) state_d = ST_DONE; else state_d = ST_SCAN;
      ST_DONE: if (out_ready)   state_d = ST_IDLE; else state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = !rst;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    idx_d       = idx_q;
    diff_d      = diff_q;
    lt_acc_d    = lt_acc_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    eq_d        = eq_q;
    lt_d        = lt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          idx_d    = IDX_TOP;
          diff_d   = 1'b0;
          lt_acc_d = 1'b0;
        end else begin
          idx_d    = idx_q;
        end
      end
      ST_SCAN: begin
        if (scan_done_s) begin
          out_valid_d = 1'b1;
          eq_d        = fin_eq_s;
          lt_d        = fin_lt_s;
          result_d    = {{(XLEN-1){1'b0}}, cmp_result_bit(op_q, fin_eq_s, fin_lt_s)};
        end else begin
          idx_d = idx_q - IDXW'(1);
          if (!diff_q && !chunk_eq_s) begin
            diff_d   = 1'b1;
            lt_acc_d = chunk_lt_s;
          end else begin
            diff_d   = diff_q;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) out_valid_d = 1'b0; else out_valid_d = 1'b1;
      end
      default: out_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_EQ;
      idx_q       <= IDX_TOP;
      diff_q      <= 1'b0;
      lt_acc_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      diff_q      <= diff_d;
      lt_acc_q    <= lt_acc_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      eq_q        <= eq_d;
      lt_q        <= lt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign eq        = eq_q;
  assign lt        = lt_q;

endmodule

// File: tb/tb_cmp_iter.sv
// Directed, table-driven bench for cmp_iter (XLEN=32, CHUNK=8); latency
// expectations follow CMP_ITER_EARLY_EXIT_EN when it is defined.
module tb_cmp_iter;
  import cmp_pkg::*;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, eq, lt;
  logic [31:0] a, b, result;
  logic [2:0]  op;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  cmp_iter #(.XLEN(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .eq(eq), .lt(lt)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        eq;
    logic        lt;
    int          lat_ee;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic int exp_lat(input int lat_ee);
`ifdef CMP_ITER_EARLY_EXIT_EN
    return lat_ee;
`else
    return NCH;
`endif
  endfunction

  // Issue one op, return cycles from acceptance edge to out_valid.
  task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] av,
                       input logic [31:0] bv, output int lat);
    int n;
    @(negedge clk);
    check({nm, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; a = av; b = bv; op = o;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
  endtask

  task automatic handshake(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, ".ov_after_hs"}, {31'd0, out_valid}, 32'd0);
    check({nm, ".rdy_after_hs"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vecs[0]  = '{"sltu_1_2",   OP_SLTU, 32'h0000_0001, 32'h0000_0002, 32'd1, 1'b0, 1'b1, 4};
    vecs[1]  = '{"slt_m1_1",   OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'd1, 1'b0, 1'b1, 1};
    vecs[2]  = '{"sltu_m1_1",  OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 1'b0, 1'b0, 1};
    vecs[3]  = '{"eq_same",    OP_EQ,   32'h1234_5678, 32'h1234_5678, 32'd1, 1'b1, 1'b0, 4};
    vecs[4]  = '{"ne_same",    OP_NE,   32'h1234_5678, 32'h1234_5678, 32'd0, 1'b1, 1'b0, 4};
    vecs[5]  = '{"geu_msb",    OP_GEU,  32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1};
    vecs[6]  = '{"ge_msb",     OP_GE,   32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, 1};
    vecs[7]  = '{"lt_eq",      OP_LT,   32'h0000_0005, 32'h0000_0005, 32'd0, 1'b1, 1'b0, 4};
    vecs[8]  = '{"ltu_chunk2", OP_LTU,  32'h0001_0000, 32'h0002_0000, 32'd1, 1'b0, 1'b1, 2};
    vecs[9]  = '{"ge_negs",    OP_GE,   32'hFFFF_FF00, 32'hFFFF_FF01, 32'd0, 1'b0, 1'b1, 4};
    vecs[10] = '{"ne_chunk1",  OP_NE,   32'h0000_0100, 32'h0000_0000, 32'd1, 1'b0, 1'b0, 3};
    vecs[11] = '{"lt_pos_neg", OP_LT,   32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 1};
    vecs[12] = '{"ltu_latch",  OP_LTU,  32'h01FF_0000, 32'h0200_0000, 32'd1, 1'b0, 1'b1, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = OP_EQ;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.result",    result,             32'd0);
    check("rst.eq",        {31'd0, eq},        32'd0);
    check("rst.lt",        {31'd0, lt},        32'd0);
    check("rst.in_ready",  {31'd0, in_ready},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.in_ready_rel", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check({vecs[i].name, ".lat"},    32'(lat),             32'(exp_lat(vecs[i].lat_ee)));
      check({vecs[i].name, ".result"}, result,               vecs[i].res);
      check({vecs[i].name, ".eq"},     {31'd0, eq},          {31'd0, vecs[i].eq});
      check({vecs[i].name, ".lt"},     {31'd0, lt},          {31'd0, vecs[i].lt});
      handshake(vecs[i].name);
    end

    // Backpressure: hold DONE with a competing request present.
    issue("bp", OP_SLTU, 32'h1, 32'h2, lat);
    check("bp.lat", 32'(lat), 32'(exp_lat(4)));
    @(negedge clk);
    in_valid = 1'b1; a = 32'h3; b = 32'h2; op = OP_SLTU;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp.hold_ov",     {31'd0, out_valid}, 32'd1);
      check("bp.hold_result", result,             32'd1);
      check("bp.hold_rdy",    {31'd0, in_ready},  32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp.hs_ov",  {31'd0, out_valid}, 32'd0);
    check("bp.hs_rdy", {31'd0, in_ready},  32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("bp.no_extra_ov",  {31'd0, out_valid}, 32'd0);
    check("bp.no_extra_rdy", {31'd0, in_ready},  32'd1);

    // Reset during the second SCAN cycle aborts the operation.
    @(negedge clk);
    in_valid = 1'b1; a = 32'h1; b = 32'h2; op = OP_SLTU;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstmid.in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid.rdy_after", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("rstmid.no_ov", {31'd0, out_valid}, 32'd0);
    end
    issue("post_rst", OP_SLTU, 32'h3, 32'h2, lat);
    check("post_rst.lat",    32'(lat),    32'(exp_lat(4)));
    check("post_rst.result", result,      32'd0);
    check("post_rst.lt",     {31'd0, lt}, 32'd0);
    handshake("post_rst");

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
